// File: rtl/wb_commit_arb.sv
// Write-back / commit arbiter: one holding buffer per long-latency unit, up to
// two buffered results granted per cycle in round-robin order onto two ports.
module wb_commit_arb #(
    parameter int NUM_SRC         = 4,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int REG_DATA_WIDTH  = 32,
    parameter int COMMIT_ID_WIDTH = 3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_SRC-1:0]                   src_valid_i,
    output logic [NUM_SRC-1:0]                   src_ready_o,
    input  logic [NUM_SRC-1:0]                   src_rd_we_i,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]    src_rd_addr_i,
    input  logic [NUM_SRC*REG_DATA_WIDTH-1:0]    src_data_i,
    input  logic [NUM_SRC*COMMIT_ID_WIDTH-1:0]   src_commit_id_i,
    output logic                                 wb1_we_o,
    output logic                                 wb2_we_o,
    output logic [REG_ADDR_WIDTH-1:0]            wb1_addr_o,
    output logic [REG_ADDR_WIDTH-1:0]            wb2_addr_o,
    output logic [REG_DATA_WIDTH-1:0]            wb1_data_o,
    output logic [REG_DATA_WIDTH-1:0]            wb2_data_o,
    output logic                                 commit_valid_o,
    output logic                                 commit_valid2_o,
    output logic [COMMIT_ID_WIDTH-1:0]           commit_id_o,
    output logic [COMMIT_ID_WIDTH-1:0]           commit_id2_o
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] NUM_SRC_C = CNT_W'(NUM_SRC);

    logic [NUM_SRC-1:0]         buf_valid_q;
    logic [NUM_SRC-1:0]         buf_we_q;
    logic [REG_ADDR_WIDTH-1:0]  buf_rd_q   [NUM_SRC];
    logic [REG_DATA_WIDTH-1:0]  buf_data_q [NUM_SRC];
    logic [COMMIT_ID_WIDTH-1:0] buf_id_q   [NUM_SRC];
    logic [PTR_W-1:0]           rr_q;
    logic [PTR_W-1:0]           rr_d;

    logic                       grant_a_s;
    logic                       cand_b_s;
    logic                       grant_b_s;
    logic                       same_rd_s;
    logic [PTR_W-1:0]           idx_a_s;
    logic [PTR_W-1:0]           idx_b_s;
    logic [CNT_W-1:0]           slot_s;
    logic [PTR_W-1:0]           slot_idx_s;
    logic [NUM_SRC-1:0]         grant_s;

    logic                       wb1_we_q, wb2_we_q;
    logic [REG_ADDR_WIDTH-1:0]  wb1_addr_q, wb2_addr_q;
    logic [REG_DATA_WIDTH-1:0]  wb1_data_q, wb2_data_q;
    logic                       cv1_q, cv2_q;
    logic [COMMIT_ID_WIDTH-1:0] id1_q, id2_q;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        logic [CNT_W-1:0] n;
        n = {1'b0, p} + CNT_W'(1);
        if (n >= NUM_SRC_C) begin
            wrap_inc = '0;
        end else begin
            wrap_inc = n[PTR_W-1:0];
        end
    endfunction

    // Round-robin scan for the first two valid buffers, then the same-rd veto on B.
    always_comb begin
        grant_a_s  = 1'b0;
        cand_b_s   = 1'b0;
        idx_a_s    = '0;
        idx_b_s    = '0;
        slot_s     = '0;
        slot_idx_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            slot_s     = {1'b0, rr_q} + CNT_W'(i);
            slot_idx_s = (slot_s >= NUM_SRC_C) ? PTR_W'(slot_s - NUM_SRC_C) : slot_s[PTR_W-1:0];
            if (buf_valid_q[slot_idx_s] && !grant_a_s) begin
                grant_a_s = 1'b1;
                idx_a_s   = slot_idx_s;
            end else if (buf_valid_q[slot_idx_s] && !cand_b_s) begin
                cand_b_s = 1'b1;
                idx_b_s  = slot_idx_s;
            end else begin
                cand_b_s = cand_b_s;
            end
        end

        same_rd_s = cand_b_s && buf_we_q[idx_a_s] && buf_we_q[idx_b_s]
                    && (buf_rd_q[idx_a_s] == buf_rd_q[idx_b_s])
                    && (buf_rd_q[idx_a_s] != '0);
        grant_b_s = cand_b_s && !same_rd_s;

        for (int k = 0; k < NUM_SRC; k++) begin
            grant_s[k] = (grant_a_s && (idx_a_s == PTR_W'(k)))
                      || (grant_b_s && (idx_b_s == PTR_W'(k)));
        end

        if (grant_b_s) begin
            rr_d = wrap_inc(idx_b_s);
        end else if (grant_a_s) begin
            rr_d = wrap_inc(idx_a_s);
        end else begin
            rr_d = rr_q;
        end
    end

    assign src_ready_o = {NUM_SRC{rst_n}} & (~buf_valid_q | grant_s);

    // Holding buffers and round-robin pointer; a granted buffer may reload on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid_q <= '0;
            buf_we_q    <= '0;
            rr_q        <= '0;
            for (int k = 0; k < NUM_SRC; k++) begin
                buf_rd_q[k]   <= '0;
                buf_data_q[k] <= '0;
                buf_id_q[k]   <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int k = 0; k < NUM_SRC; k++) begin
                if (src_valid_i[k] && src_ready_o[k]) begin
                    buf_valid_q[k] <= 1'b1;
                    buf_we_q[k]    <= src_rd_we_i[k];
                    buf_rd_q[k]    <= src_rd_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                    buf_data_q[k]  <= src_data_i[k*REG_DATA_WIDTH +: REG_DATA_WIDTH];
                    buf_id_q[k]    <= src_commit_id_i[k*COMMIT_ID_WIDTH +: COMMIT_ID_WIDTH];
                end else if (grant_s[k]) begin
                    buf_valid_q[k] <= 1'b0;
                end else begin
                    buf_valid_q[k] <= buf_valid_q[k];
                end
            end
        end
    end

    // Port registers: an ungranted port drops valid/we but keeps its last addr/data/id.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cv1_q      <= 1'b0;
            cv2_q      <= 1'b0;
            wb1_we_q   <= 1'b0;
            wb2_we_q   <= 1'b0;
            wb1_addr_q <= '0;
            wb2_addr_q <= '0;
            wb1_data_q <= '0;
            wb2_data_q <= '0;
            id1_q      <= '0;
            id2_q      <= '0;
        end else begin
            cv1_q    <= grant_a_s;
            cv2_q    <= grant_b_s;
            wb1_we_q <= grant_a_s && buf_we_q[idx_a_s] && (buf_rd_q[idx_a_s] != '0);
            wb2_we_q <= grant_b_s && buf_we_q[idx_b_s] && (buf_rd_q[idx_b_s] != '0);
            if (grant_a_s) begin
                wb1_addr_q <= buf_rd_q[idx_a_s];
                wb1_data_q <= buf_data_q[idx_a_s];
                id1_q      <= buf_id_q[idx_a_s];
            end else begin
                wb1_addr_q <= wb1_addr_q;
            end
            if (grant_b_s) begin
                wb2_addr_q <= buf_rd_q[idx_b_s];
                wb2_data_q <= buf_data_q[idx_b_s];
                id2_q      <= buf_id_q[idx_b_s];
            end else begin
                wb2_addr_q <= wb2_addr_q;
            end
        end
    end

    assign commit_valid_o  = cv1_q;
    assign commit_valid2_o = cv2_q;
    assign commit_id_o     = id1_q;
    assign commit_id2_o    = id2_q;
    assign wb1_we_o        = wb1_we_q;
    assign wb2_we_o        = wb2_we_q;
    assign wb1_addr_o      = wb1_addr_q;
    assign wb2_addr_o      = wb2_addr_q;
    assign wb1_data_o      = wb1_data_q;
    assign wb2_data_o      = wb2_data_q;

endmodule
